// File: rtl/ad_trig_capture_pkg.sv
// Shared definitions for the triggered ADC capture block: default sizes and
// the capture FSM state encoding.
package ad_trig_capture_pkg;

  localparam int DW_DEF    = 16;
  localparam int DEPTH_DEF = 256;
  localparam int AW_DEF    = 8;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARMED   = 2'd1,
    CAPTURE = 2'd2,
    READOUT = 2'd3
  } cap_state_e;

endpackage

// File: rtl/ad_trig_capture_if.sv
// Sample input, trigger control and read-out stream of the capture block.
// The master side drives the controls; the slave side is the capture block.
interface ad_trig_capture_if
  import ad_trig_capture_pkg::*;
#(
  parameter int DW = DW_DEF
);

  logic [DW-1:0] ad_din;
  logic          arm;
  logic          force_trig;
  logic [DW-1:0] thr;
  logic [DW-1:0] dout;
  logic          dout_valid;
  logic          dout_ready;
  logic          dout_last;
  logic          busy;
  logic          done;

  modport master (
    output ad_din, arm, force_trig, thr, dout_ready,
    input  dout, dout_valid, dout_last, busy, done
  );

  modport slave (
    input  ad_din, arm, force_trig, thr, dout_ready,
    output dout, dout_valid, dout_last, busy, done
  );

endinterface

// File: rtl/ad_cap_ram.sv
// Simple dual-port capture buffer: one write port and one registered read
// port with read enable, so the read data holds while the consumer stalls.
module ad_cap_ram #(
  parameter int DW = 16,
  parameter int AW = 8
) (
  input  logic          clk_i,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [DW-1:0] wdata_i,
  input  logic          re_i,
  input  logic [AW-1:0] raddr_i,
  output logic [DW-1:0] rdata_o
);

  logic [DW-1:0] mem [0:(1<<AW)-1];
  logic [DW-1:0] rdata_q;

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem[waddr_i] <= wdata_i;
    end
    if (re_i) begin
      rdata_q <= mem[raddr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/ad_trig_capture.sv
// Rising-edge triggered capture of DEPTH ADC samples into a buffer, followed
// by an in-order valid/ready read-out of the whole frame.
module ad_trig_capture
  import ad_trig_capture_pkg::*;
#(
  parameter int DW    = DW_DEF,
  parameter int DEPTH = DEPTH_DEF,
  parameter int AW    = AW_DEF
) (
  input  logic               clkin_bufr,
  input  logic               io_reset,
  ad_trig_capture_if.slave   bus
);

  localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);

  cap_state_e           state_q, state_d;
  logic signed [DW-1:0] thrL_q, thrL_d;
  logic signed [DW-1:0] prev_q, prev_d;
  logic                 armFirst_q, armFirst_d;
  logic [AW-1:0]        wcnt_q, wcnt_d;
  logic [AW-1:0]        rcnt_q, rcnt_d;
  logic [AW-1:0]        outIdx_q, outIdx_d;
  logic                 fetchDone_q, fetchDone_d;
  logic                 valid_q, valid_d;

  logic                 we;
  logic [AW-1:0]        waddr;
  logic                 re;
  logic [DW-1:0]        rdata;
  logic                 trig;
  logic                 xfer;
  logic                 isLast;

  ad_cap_ram #(.DW(DW), .AW(AW)) u_ram (
    .clk_i   (clkin_bufr),
    .we_i    (we),
    .waddr_i (waddr),
    .wdata_i (bus.ad_din),
    .re_i    (re),
    .raddr_i (rcnt_q),
    .rdata_o (rdata)
  );

  assign isLast = valid_q && (outIdx_q == LAST_ADDR);
  assign xfer   = valid_q && bus.dout_ready;
  // The first ARMED cycle only primes prev_q, so an input already above the
  // threshold at arm time cannot look like a crossing.
  assign trig   = (state_q == ARMED) && !armFirst_q &&
                  (bus.force_trig ||
                   ((prev_q < thrL_q) && ($signed(bus.ad_din) >= thrL_q)));

  always_comb begin
    state_d     = state_q;
    thrL_d      = thrL_q;
    prev_d      = prev_q;
    armFirst_d  = armFirst_q;
    wcnt_d      = wcnt_q;
    rcnt_d      = rcnt_q;
    outIdx_d    = outIdx_q;
    fetchDone_d = fetchDone_q;
    valid_d     = valid_q;
    we          = 1'b0;
    waddr       = wcnt_q;
    re          = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.arm) begin
          thrL_d      = $signed(bus.thr);
          armFirst_d  = 1'b1;
          wcnt_d      = '0;
          rcnt_d      = '0;
          fetchDone_d = 1'b0;
          valid_d     = 1'b0;
          state_d     = ARMED;
        end
      end
      ARMED: begin
        prev_d     = $signed(bus.ad_din);
        armFirst_d = 1'b0;
        if (bus.arm) begin
          thrL_d = $signed(bus.thr);
        end
        if (trig) begin
          we      = 1'b1;
          waddr   = '0;
          wcnt_d  = AW'(1);
          state_d = CAPTURE;
        end
      end
      CAPTURE: begin
        we     = 1'b1;
        wcnt_d = wcnt_q + 1'b1;
        if (wcnt_q == LAST_ADDR) begin
          wcnt_d      = '0;
          rcnt_d      = '0;
          fetchDone_d = 1'b0;
          valid_d     = 1'b0;
          state_d     = READOUT;
        end
      end
      READOUT: begin
        // The RAM output register is the holding stage: fetch only when it is
        // empty or being drained, so a stalled sample never changes.
        re = !fetchDone_q && (!valid_q || bus.dout_ready);
        if (re) begin
          outIdx_d = rcnt_q;
          rcnt_d   = rcnt_q + 1'b1;
          valid_d  = 1'b1;
          if (rcnt_q == LAST_ADDR) begin
            fetchDone_d = 1'b1;
          end
        end else if (xfer) begin
          valid_d = 1'b0;
        end
        if (xfer && isLast) begin
          valid_d = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clkin_bufr) begin
    if (io_reset) begin
      state_q     <= IDLE;
      thrL_q      <= '0;
      prev_q      <= '0;
      armFirst_q  <= 1'b0;
      wcnt_q      <= '0;
      rcnt_q      <= '0;
      outIdx_q    <= '0;
      fetchDone_q <= 1'b0;
      valid_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      thrL_q      <= thrL_d;
      prev_q      <= prev_d;
      armFirst_q  <= armFirst_d;
      wcnt_q      <= wcnt_d;
      rcnt_q      <= rcnt_d;
      outIdx_q    <= outIdx_d;
      fetchDone_q <= fetchDone_d;
      valid_q     <= valid_d;
    end
  end

  assign bus.dout       = valid_q ? rdata : '0;
  assign bus.dout_valid = valid_q;
  assign bus.dout_last  = isLast;
  assign bus.busy       = (state_q != IDLE);
  assign bus.done       = xfer && isLast;

endmodule

// File: tb/tb_ad_trig_capture.sv
// Directed bench for ad_trig_capture: ramp, backpressure, forced trigger,
// no-false-trigger, mid-operation reset and ignored controls.
module tb_ad_trig_capture;
  import ad_trig_capture_pkg::*;

  localparam int DW    = 16;
  localparam int DEPTH = 256;

  logic clkin_bufr;
  logic io_reset;
  int   checks;
  int   errors;

  ad_trig_capture_if #(.DW(DW)) bus ();

  ad_trig_capture #(.DW(DW), .DEPTH(DEPTH), .AW(8)) dut (
    .clkin_bufr (clkin_bufr),
    .io_reset   (io_reset),
    .bus        (bus)
  );

  initial clkin_bufr = 1'b0;
  always #5 clkin_bufr = ~clkin_bufr;

  task automatic test_reset();
    io_reset       = 1'b1;
    bus.arm        = 1'b0;
    bus.force_trig = 1'b0;
    bus.dout_ready = 1'b0;
    bus.ad_din     = '0;
    bus.thr        = '0;
    repeat (2) @(posedge clkin_bufr);
    @(negedge clkin_bufr);
    #1;
    checks++;
    if (bus.dout !== 16'd0 || bus.dout_valid !== 1'b0 || bus.dout_last !== 1'b0 ||
        bus.busy !== 1'b0 || bus.done !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_state: dout=%h valid=%b last=%b busy=%b done=%b, required all 0",
               bus.dout, bus.dout_valid, bus.dout_last, bus.busy, bus.done);
    end
    io_reset = 1'b0;
  endtask

  // Drives one frame from IDLE and checks every presented sample, the stall
  // behaviour, done, latency and the return to IDLE.
  task automatic runFrame(input string name, input bit useForce, input int forceAt,
                          input int trigIdx, input int start, input int step,
                          input int dinMax, input int readyPct, input bit pulseCtl,
                          input int thrVal, input int expFirst, input int expStep);
    int          n;
    int          v;
    int          firstValid;
    bit          pulse;
    bit          prevValid;
    bit          prevReady;
    bit          prevLast;
    logic [15:0] prevDout;
    logic [15:0] expv;
    bit          expDone;
    n          = 0;
    firstValid = -1;
    prevValid  = 1'b0;
    prevReady  = 1'b0;
    prevLast   = 1'b0;
    prevDout   = '0;
    io_reset   = 1'b0;
    bus.thr    = 16'(thrVal);
    for (int idx = 0; idx < 4000 && n < DEPTH; idx++) begin
      @(negedge clkin_bufr);
      v = start + step * idx;
      if (v > dinMax) v = dinMax;
      bus.ad_din     = 16'(v);
      pulse          = pulseCtl && (idx > trigIdx) && (idx % 37 == 0);
      bus.arm        = (idx == 0) || pulse;
      bus.force_trig = (useForce && idx == forceAt) || pulse;
      bus.dout_ready = ($urandom_range(0, 99) < readyPct);
      #1;
      if (idx <= trigIdx) begin
        checks++;
        if (bus.busy !== (idx > 0) || bus.dout_valid !== 1'b0) begin
          errors++;
          $display("[TB] FAIL %s armed_idx%0d: busy=%b valid=%b, required busy=%b valid=0",
                   name, idx, bus.busy, bus.dout_valid, (idx > 0));
        end
      end
      if (prevValid && !prevReady) begin
        checks++;
        if (bus.dout_valid !== 1'b1 || bus.dout !== prevDout || bus.dout_last !== prevLast) begin
          errors++;
          $display("[TB] FAIL %s stall_hold n=%0d: valid=%b dout=%h last=%b, required 1 %h %b",
                   name, n, bus.dout_valid, bus.dout, bus.dout_last, prevDout, prevLast);
        end
      end
      expDone = (bus.dout_valid === 1'b1) && bus.dout_ready && (n == DEPTH - 1);
      checks++;
      if (bus.done !== expDone) begin
        errors++;
        $display("[TB] FAIL %s done n=%0d: done=%b, required %b", name, n, bus.done, expDone);
      end
      if (bus.dout_valid === 1'b1) begin
        if (firstValid < 0) begin
          firstValid = idx;
          checks++;
          if (idx > trigIdx + 258) begin
            errors++;
            $display("[TB] FAIL %s first_valid_latency: at idx %0d, required <= %0d",
                     name, idx, trigIdx + 258);
          end
        end
        expv = 16'(expFirst + expStep * n);
        checks++;
        if (bus.dout !== expv || bus.dout_last !== (n == DEPTH - 1)) begin
          errors++;
          $display("[TB] FAIL %s sample%0d: dout=%0d last=%b, required dout=%0d last=%b",
                   name, n, $signed(bus.dout), bus.dout_last, $signed(expv), (n == DEPTH - 1));
        end
        if (bus.dout_ready) n++;
      end
      prevValid = (bus.dout_valid === 1'b1);
      prevReady = bus.dout_ready;
      prevDout  = bus.dout;
      prevLast  = bus.dout_last;
    end
    if (n < DEPTH) begin
      checks++;
      errors++;
      $display("[TB] FAIL %s timeout: %0d samples read, required %0d", name, n, DEPTH);
    end
    @(negedge clkin_bufr);
    bus.arm        = 1'b0;
    bus.force_trig = 1'b0;
    #1;
    checks++;
    if (bus.dout_valid !== 1'b0 || bus.busy !== 1'b0 || bus.done !== 1'b0) begin
      errors++;
      $display("[TB] FAIL %s end_idle: valid=%b busy=%b done=%b, required 0 0 0",
               name, bus.dout_valid, bus.busy, bus.done);
    end
    repeat (3) @(negedge clkin_bufr);
    #1;
    checks++;
    if (bus.busy !== 1'b0 || bus.dout_valid !== 1'b0) begin
      errors++;
      $display("[TB] FAIL %s stays_idle: busy=%b valid=%b, required 0 0",
               name, bus.busy, bus.dout_valid);
    end
  endtask

  task automatic test_ramp();
    runFrame("ramp", 1'b0, -1, 150, -50, 1, 400, 100, 1'b0, 100, 100, 1);
  endtask

  task automatic test_backpressure();
    runFrame("backpressure", 1'b0, -1, 150, -50, 1, 400, 30, 1'b0, 100, 100, 1);
  endtask

  task automatic test_force_trigger();
    runFrame("force", 1'b1, 4, 4, -5, 0, 40000, 100, 1'b0, 32767, -5, 0);
  endtask

  task automatic test_no_false_trigger();
    int bad;
    bad            = 0;
    io_reset       = 1'b0;
    bus.thr        = 16'd100;
    bus.ad_din     = 16'd200;
    bus.force_trig = 1'b0;
    bus.dout_ready = 1'b1;
    @(negedge clkin_bufr);
    bus.arm = 1'b1;
    @(negedge clkin_bufr);
    bus.arm = 1'b0;
    for (int i = 0; i < 1000; i++) begin
      #1;
      checks++;
      if (bus.busy !== 1'b1 || bus.dout_valid !== 1'b0) begin
        errors++;
        bad++;
        if (bad < 5)
          $display("[TB] FAIL no_false_trigger cycle%0d: busy=%b valid=%b, required 1 0",
                   i, bus.busy, bus.dout_valid);
      end
      @(negedge clkin_bufr);
    end
    io_reset = 1'b1;
    @(negedge clkin_bufr);
    io_reset = 1'b0;
    #1;
    checks++;
    if (bus.busy !== 1'b0) begin
      errors++;
      $display("[TB] FAIL no_false_trigger reset_exit: busy=%b, required 0", bus.busy);
    end
  endtask

  task automatic test_reset_mid();
    int n;
    int seenValid;
    logic [15:0] expv;
    io_reset       = 1'b0;
    bus.thr        = 16'sd32767;
    bus.dout_ready = 1'b1;
    // Reset while capture sample 50 is being written.
    for (int idx = 0; idx <= 53; idx++) begin
      @(negedge clkin_bufr);
      bus.ad_din     = 16'(1000 + idx);
      bus.arm        = (idx == 0);
      bus.force_trig = (idx == 3);
      io_reset       = (idx == 53);
    end
    @(negedge clkin_bufr);
    io_reset       = 1'b0;
    bus.arm        = 1'b0;
    bus.force_trig = 1'b0;
    #1;
    checks++;
    if (bus.dout !== 16'd0 || bus.dout_valid !== 1'b0 || bus.dout_last !== 1'b0 ||
        bus.busy !== 1'b0 || bus.done !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_mid_capture: dout=%h valid=%b last=%b busy=%b done=%b, required all 0",
               bus.dout, bus.dout_valid, bus.dout_last, bus.busy, bus.done);
    end
    seenValid = 0;
    repeat (300) begin
      @(negedge clkin_bufr);
      #1;
      if (bus.dout_valid === 1'b1 || bus.busy === 1'b1) seenValid++;
    end
    checks++;
    if (seenValid != 0) begin
      errors++;
      $display("[TB] FAIL reset_mid_capture idle: %0d active cycles, required 0", seenValid);
    end
    // Reset while read-out sample 10 is presented.
    n = 0;
    for (int idx = 0; idx < 600; idx++) begin
      @(negedge clkin_bufr);
      if (n == 10) begin
        io_reset = 1'b1;
        break;
      end
      bus.ad_din     = 16'(3000 + idx);
      bus.arm        = (idx == 0);
      bus.force_trig = (idx == 3);
      #1;
      if (bus.dout_valid === 1'b1 && bus.dout_ready) begin
        expv = 16'(3003 + n);
        checks++;
        if (bus.dout !== expv) begin
          errors++;
          $display("[TB] FAIL reset_mid_readout sample%0d: dout=%0d, required %0d",
                   n, bus.dout, expv);
        end
        n++;
      end
    end
    checks++;
    if (n != 10) begin
      errors++;
      $display("[TB] FAIL reset_mid_readout timeout: %0d samples, required 10", n);
    end
    @(negedge clkin_bufr);
    io_reset       = 1'b0;
    bus.arm        = 1'b0;
    bus.force_trig = 1'b0;
    #1;
    checks++;
    if (bus.dout !== 16'd0 || bus.dout_valid !== 1'b0 || bus.dout_last !== 1'b0 ||
        bus.busy !== 1'b0 || bus.done !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_mid_readout: dout=%h valid=%b last=%b busy=%b done=%b, required all 0",
               bus.dout, bus.dout_valid, bus.dout_last, bus.busy, bus.done);
    end
    seenValid = 0;
    repeat (20) begin
      @(negedge clkin_bufr);
      #1;
      if (bus.dout_valid === 1'b1) seenValid++;
    end
    checks++;
    if (seenValid != 0) begin
      errors++;
      $display("[TB] FAIL reset_mid_readout no_partial: %0d valid cycles, required 0", seenValid);
    end
    runFrame("after_reset", 1'b1, 4, 4, 5000, 1, 40000, 100, 1'b0, 32767, 5004, 1);
  endtask

  task automatic test_ignored_controls();
    runFrame("ignored_ctl", 1'b1, 6, 6, -2000, 3, 40000, 70, 1'b1, 32767, -1982, 3);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_ramp();
    test_backpressure();
    test_force_trigger();
    test_no_false_trigger();
    test_reset_mid();
    test_ignored_controls();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ad_trig_capture.md
AD_TRIG_CAPTURE -- requirements
Module: ad_trig_capture

Interface
REQ-001 Parameter DW, 16, sample width in bits.
REQ-002 Parameter DEPTH, 256, samples per capture frame (power of two).
REQ-003 Parameter AW, 8, buffer address width, equal to log2(DEPTH).
REQ-004 Port clkin_bufr, input, 1: single clock; all logic is sampled on its rising edge.
REQ-005 Port io_reset, input, 1: reset, synchronous and active-high.
REQ-006 Port ad_din, input, DW: processed ADC sample, two's complement, one new sample per cycle.
REQ-007 Port arm, input, 1: single-cycle request to arm the trigger.
REQ-008 Port force_trig, input, 1: software trigger that bypasses the threshold compare.
REQ-009 Port thr, input, DW: signed trigger threshold, sampled when arm is accepted.
REQ-010 Port dout, output, DW: read-out sample.
REQ-011 Port dout_valid, output, 1: dout holds a valid sample.
REQ-012 Port dout_ready, input, 1: downstream accepts dout this cycle.
REQ-013 Port dout_last, output, 1: asserted with dout_valid on frame sample DEPTH-1.
REQ-014 Port busy, output, 1: high in every state except IDLE.
REQ-015 Port done, output, 1: one-cycle pulse when the last sample is accepted.

Function
REQ-016 The FSM SHALL have four states: IDLE, ARMED, CAPTURE, READOUT.
REQ-017 IDLE -> ARMED when arm=1; thr is latched in the same cycle.
REQ-018 In ARMED, the first cycle after entry SHALL only load the previous-sample register and SHALL NOT evaluate the trigger.
REQ-019 Trigger in ARMED SHALL fire on (prev < thr_l) and (ad_din >= thr_l), signed compare, or on force_trig=1; simultaneous conditions produce a single trigger.
REQ-020 On trigger, ad_din of that cycle SHALL be written at address 0, and the state becomes CAPTURE.
REQ-021 In CAPTURE, one sample per cycle SHALL be written at consecutive addresses; after address DEPTH-1 is written, the state becomes READOUT (exactly DEPTH samples, no gaps).
REQ-022 In READOUT, samples SHALL be presented in address order 0..DEPTH-1, with a buffer read latency of 1 cycle hidden by prefetch.
REQ-023 The first dout_valid SHALL assert no later than 2 cycles after READOUT entry.
REQ-024 While dout_valid=1 and dout_ready=0, dout, dout_valid and dout_last SHALL hold stable.
REQ-025 With dout_ready held at 1, one sample SHALL transfer per cycle with no bubbles.
REQ-026 A sample transfers on dout_valid and dout_ready both high.
REQ-027 On transfer of sample DEPTH-1: done pulses for 1 cycle, dout_valid drops the next cycle, and the state returns to IDLE.
REQ-028 arm and force_trig SHALL be ignored in CAPTURE and READOUT.
REQ-029 arm in ARMED SHALL re-latch thr without restarting the ARMED state.
REQ-030 force_trig in IDLE SHALL be ignored.
REQ-031 The write and read address counters SHALL be AW bits wide; frame end is detected by count == DEPTH-1, not by wrap-around.

Reset
REQ-032 On io_reset=1 at a clock edge, state SHALL go to IDLE in any state, including mid-CAPTURE or mid-READOUT.
REQ-033 On reset, dout, dout_valid, dout_last, busy and done SHALL be 0, and the counters, thr_l and prev SHALL be 0.
REQ-034 Buffer contents are not reset; a partial frame SHALL NOT be read out after reset.

Structure
REQ-035 A shared package/include SHALL hold the FSM state encoding and the DW/DEPTH/AW defaults.
REQ-036 The buffer SHALL be a sub-module ad_cap_ram: simple dual-port, one write port and one registered read port, inferable as block RAM.

Verification
REQ-037 Ramp test: thr=100, arm, ad_din ramps -50..+400 step 1, dout_ready=1 -> trigger on sample 100; dout = 100..355; dout_last on 355; done pulses once.
REQ-038 Backpressure: dout_ready random 30% duty -> sequence identical to REQ-037, and dout stays stable during every stall.
REQ-039 Force trigger: thr=32767, constant ad_din=-5, force_trig pulse -> 256 samples of -5 are read out.
REQ-040 No false trigger: arm, then ad_din=200 already above thr=100 and held for 1000 cycles -> stays in ARMED with busy=1 and dout_valid=0 throughout.
REQ-041 Reset mid-operation: io_reset at capture sample 50 and again at read-out sample 10 -> next cycle IDLE, all outputs 0, and a new arm completes a correct frame.
REQ-042 Ignored controls: arm and force_trig pulsed during CAPTURE and READOUT -> exactly one frame; returns to IDLE.
